// File: rtl/rs_codeword_demap_if.sv
// rtl/rs_codeword_demap_if.sv - codeword-group input and AM-mapped flow output bundle for rs_codeword_demap
interface rs_codeword_demap_if #(
    parameter int WIDTH_WORD_RS   = 5440,
    parameter int AM_MAPPED_WIDTH = 10280,
    parameter int ERR_CNT_W       = 16
);
    logic                       i_valid;
    logic                       o_ready;
    logic [WIDTH_WORD_RS-1:0]   word_A;
    logic [WIDTH_WORD_RS-1:0]   word_B;
    logic [WIDTH_WORD_RS-1:0]   word_C;
    logic [WIDTH_WORD_RS-1:0]   word_D;
    logic                       o_valid;
    logic                       i_ready;
    logic [AM_MAPPED_WIDTH-1:0] rx_f0;
    logic [AM_MAPPED_WIDTH-1:0] rx_f1;
    logic                       o_am_start;
    logic [3:0]                 o_par_err;
    logic [ERR_CNT_W-1:0]       o_err_cnt;

    modport slave (
        input  i_valid, word_A, word_B, word_C, word_D, i_ready,
        output o_ready, o_valid, rx_f0, rx_f1, o_am_start, o_par_err, o_err_cnt
    );

    modport master (
        output i_valid, word_A, word_B, word_C, word_D, i_ready,
        input  o_ready, o_valid, rx_f0, rx_f1, o_am_start, o_par_err, o_err_cnt
    );
endinterface

// File: rtl/rs_codeword_demap.sv
// rtl/rs_codeword_demap.sv - strips RS parity, de-interleaves A/B and C/D into two flows via a 2-entry buffer
// Optional fixed-pattern parity-field check: RS_DEMAP_PARITY_CHECK_EN.
module rs_codeword_demap #(
    parameter int WORD_SIZE       = 10,
    parameter int WIDTH_WORD_RS   = 5440,
    parameter int MSG_SYMBOLS     = 514,
    parameter int AM_MAPPED_WIDTH = 10280,
    parameter int GROUPS_PER_AM   = 8192,
    parameter int ERR_CNT_W       = 16
) (
    input  logic                clk,
    input  logic                rst,
    rs_codeword_demap_if.slave  bus
);
    localparam int PAR_W = WIDTH_WORD_RS - MSG_SYMBOLS * WORD_SIZE;
    localparam int GRP_W = $clog2(GROUPS_PER_AM);
    localparam logic [GRP_W-1:0] GRP_LAST = GRP_W'(GROUPS_PER_AM - 1);

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t                     state_q, state_d;
    logic                       rdy_q;
    logic                       valid;
    logic                       in_fire, out_fire;
    logic                       load_head, head_from_tail, load_tail;
    logic [AM_MAPPED_WIDTH-1:0] in_f0, in_f1;
    logic [AM_MAPPED_WIDTH-1:0] head_f0, head_f1, tail_f0, tail_f1;
    logic [3:0]                 in_err, head_err, tail_err;
    logic [GRP_W-1:0]           grp_cnt;

    // Symbol 0 sits at the MSB end of a codeword; flow symbol 2l/2l+1 take codeword symbol l.
    function automatic logic [AM_MAPPED_WIDTH-1:0] interleave(
        input logic [WIDTH_WORD_RS-1:0] x,
        input logic [WIDTH_WORD_RS-1:0] y
    );
        logic [AM_MAPPED_WIDTH-1:0] r;
        r = '0;
        for (int l = 0; l < MSG_SYMBOLS; l++) begin
            r[2*WORD_SIZE*l +: WORD_SIZE]           = x[WIDTH_WORD_RS-1-WORD_SIZE*l -: WORD_SIZE];
            r[2*WORD_SIZE*l+WORD_SIZE +: WORD_SIZE] = y[WIDTH_WORD_RS-1-WORD_SIZE*l -: WORD_SIZE];
        end
        return r;
    endfunction

    assign in_f0 = interleave(bus.word_A, bus.word_B);
    assign in_f1 = interleave(bus.word_C, bus.word_D);

`ifdef RS_DEMAP_PARITY_CHECK_EN
    localparam logic [PAR_W-1:0] PH_A = '0;
    localparam logic [PAR_W-1:0] PH_B = {(PAR_W/2){2'b01}};
    localparam logic [PAR_W-1:0] PH_C = {(PAR_W/2){2'b10}};
    localparam logic [PAR_W-1:0] PH_D = '1;

    assign in_err = {bus.word_D[PAR_W-1:0] != PH_D, bus.word_C[PAR_W-1:0] != PH_C,
                     bus.word_B[PAR_W-1:0] != PH_B, bus.word_A[PAR_W-1:0] != PH_A};
`else
    logic unused_par;
    assign unused_par = ^{bus.word_A[PAR_W-1:0], bus.word_B[PAR_W-1:0],
                          bus.word_C[PAR_W-1:0], bus.word_D[PAR_W-1:0]};
    assign in_err = 4'b0000;
`endif

    assign valid    = (state_q != EMPTY);
    assign in_fire  = bus.i_valid & rdy_q;
    assign out_fire = valid & bus.i_ready;

    always_comb begin
        state_d        = state_q;
        load_head      = 1'b0;
        head_from_tail = 1'b0;
        load_tail      = 1'b0;
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    state_d   = ONE;
                    load_head = 1'b1;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    load_head = 1'b1;
                end else if (in_fire) begin
                    state_d   = FULL;
                    load_tail = 1'b1;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    state_d        = ONE;
                    head_from_tail = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // Ready is registered from the next occupancy so it never combinationally follows i_ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= EMPTY;
            rdy_q    <= 1'b0;
            head_f0  <= '0;
            head_f1  <= '0;
            head_err <= '0;
            grp_cnt  <= '0;
        end else begin
            state_q <= state_d;
            rdy_q   <= (state_d != FULL);
            if (load_head) begin
                head_f0  <= in_f0;
                head_f1  <= in_f1;
                head_err <= in_err;
            end else if (head_from_tail) begin
                head_f0  <= tail_f0;
                head_f1  <= tail_f1;
                head_err <= tail_err;
            end
            if (out_fire) begin
                grp_cnt <= (grp_cnt == GRP_LAST) ? '0 : grp_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (load_tail) begin
            tail_f0  <= in_f0;
            tail_f1  <= in_f1;
            tail_err <= in_err;
        end
    end

`ifdef RS_DEMAP_PARITY_CHECK_EN
    logic [ERR_CNT_W-1:0] err_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (out_fire && (|head_err) && (err_cnt != '1)) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

    assign bus.o_err_cnt = err_cnt;
`else
    assign bus.o_err_cnt = '0;
`endif

    assign bus.o_ready    = rdy_q;
    assign bus.o_valid    = valid;
    assign bus.rx_f0      = head_f0;
    assign bus.rx_f1      = head_f1;
    assign bus.o_par_err  = head_err;
    assign bus.o_am_start = (grp_cnt == '0) & valid;
endmodule

// File: tb/tb_rs_codeword_demap.sv
// tb/tb_rs_codeword_demap.sv - randomized scenario bench for rs_codeword_demap against a queue reference model
module tb_rs_codeword_demap;
    localparam int WS  = 10;
    localparam int WR  = 5440;
    localparam int MS  = 514;
    localparam int AMW = 10280;
    localparam int GPA = 4;
    localparam int ECW = 16;
    localparam int PW  = WR - MS * WS;
    localparam int NSYM_CW = WR / WS;

    typedef struct {
        logic [AMW-1:0] f0;
        logic [AMW-1:0] f1;
        logic [3:0]     err;
    } grp_t;

    logic clk;
    logic rst;

    rs_codeword_demap_if #(.WIDTH_WORD_RS(WR), .AM_MAPPED_WIDTH(AMW), .ERR_CNT_W(ECW)) bus ();

    rs_codeword_demap #(
        .WORD_SIZE(WS), .WIDTH_WORD_RS(WR), .MSG_SYMBOLS(MS),
        .AM_MAPPED_WIDTH(AMW), .GROUPS_PER_AM(GPA), .ERR_CNT_W(ECW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    grp_t           q[$];
    int             out_cnt;
    int             exp_err_cnt;
    int             n_vec;
    int             n_bad;
    logic [WR-1:0]  wa, wb, wc, wd;

    function automatic logic [WS-1:0] cw_sym(input logic [WR-1:0] w, input int l);
        logic [WR-1:0] t;
        t = w >> (WS * (NSYM_CW - 1 - l));
        return t[WS-1:0];
    endfunction

    function automatic logic [WS-1:0] flow_sym(input logic [AMW-1:0] f, input int k);
        logic [AMW-1:0] t;
        t = f >> (WS * k);
        return t[WS-1:0];
    endfunction

    function automatic int first_diff(input logic [AMW-1:0] x, input logic [AMW-1:0] y);
        for (int k = 0; k < AMW / WS; k++)
            if (flow_sym(x, k) !== flow_sym(y, k)) return k;
        return 0;
    endfunction

    function automatic logic [PW-1:0] par_fill(input int idx);
        logic [PW-1:0] p;
        for (int i = 0; i < PW; i++) begin
            case (idx)
                0:       p[i] = 1'b0;
                1:       p[i] = (i % 2 == 0);
                2:       p[i] = (i % 2 == 1);
                default: p[i] = 1'b1;
            endcase
        end
        return p;
    endfunction

    function automatic logic [AMW-1:0] ref_flow(input logic [WR-1:0] x, input logic [WR-1:0] y);
        logic [AMW-1:0] f;
        f = '0;
        for (int l = 0; l < MS; l++) begin
            f = f | (AMW'(cw_sym(x, l)) << (2 * WS * l));
            f = f | (AMW'(cw_sym(y, l)) << (2 * WS * l + WS));
        end
        return f;
    endfunction

    function automatic grp_t ref_group(input logic [WR-1:0] a, input logic [WR-1:0] b,
                                       input logic [WR-1:0] c, input logic [WR-1:0] d);
        grp_t g;
        g.f0 = ref_flow(a, b);
        g.f1 = ref_flow(c, d);
`ifdef RS_DEMAP_PARITY_CHECK_EN
        g.err = {d[PW-1:0] != par_fill(3), c[PW-1:0] != par_fill(2),
                 b[PW-1:0] != par_fill(1), a[PW-1:0] != par_fill(0)};
`else
        g.err = 4'b0000;
`endif
        return g;
    endfunction

    function automatic logic [WR-1:0] make_word(input int idx);
        logic [WR-1:0] w;
        w = '0;
        for (int l = 0; l < MS; l++) begin
            logic [7:0] lo;
            lo = l[7:0];
            w = w | (WR'({idx[1:0], lo}) << (WS * (NSYM_CW - 1 - l)));
        end
        w[PW-1:0] = par_fill(idx);
        return w;
    endfunction

    task automatic rand_words();
        for (int i = 0; i < WR / 32; i++) begin
            wa[32*i +: 32] = $urandom;
            wb[32*i +: 32] = $urandom;
            wc[32*i +: 32] = $urandom;
            wd[32*i +: 32] = $urandom;
        end
    endtask

    task automatic pattern_words();
        wa = make_word(0);
        wb = make_word(1);
        wc = make_word(2);
        wd = make_word(3);
    endtask

    // One clock: drive inputs, compare DUT state against the model, then advance the model.
    task automatic cycle(input bit v, input bit r);
        grp_t e;
        bit   exp_v, exp_am, acc;
        int   k;
        bus.i_valid = v;
        bus.i_ready = r;
        bus.word_A  = wa;
        bus.word_B  = wb;
        bus.word_C  = wc;
        bus.word_D  = wd;
        #1;
        exp_v  = (q.size() > 0);
        exp_am = exp_v && (out_cnt % GPA == 0);
        acc    = v && (q.size() < 2);
        n_vec++;
        if (bus.o_valid !== exp_v) begin
            n_bad++;
            $display("FAIL o_valid: got %b expected %b", bus.o_valid, exp_v);
        end
        n_vec++;
        if (bus.o_ready !== (q.size() < 2)) begin
            n_bad++;
            $display("FAIL o_ready: got %b expected %b", bus.o_ready, (q.size() < 2));
        end
        n_vec++;
        if (bus.o_am_start !== exp_am) begin
            n_bad++;
            $display("FAIL o_am_start: got %b expected %b (output %0d)", bus.o_am_start, exp_am, out_cnt);
        end
        n_vec++;
        if (bus.o_err_cnt !== ECW'(exp_err_cnt)) begin
            n_bad++;
            $display("FAIL o_err_cnt: got %0d expected %0d", bus.o_err_cnt, exp_err_cnt);
        end
        if (exp_v) begin
            e = q[0];
            n_vec++;
            if (bus.rx_f0 !== e.f0) begin
                n_bad++;
                k = first_diff(bus.rx_f0, e.f0);
                $display("FAIL rx_f0: symbol %0d got %h expected %h", k, flow_sym(bus.rx_f0, k), flow_sym(e.f0, k));
            end
            n_vec++;
            if (bus.rx_f1 !== e.f1) begin
                n_bad++;
                k = first_diff(bus.rx_f1, e.f1);
                $display("FAIL rx_f1: symbol %0d got %h expected %h", k, flow_sym(bus.rx_f1, k), flow_sym(e.f1, k));
            end
            n_vec++;
            if (bus.o_par_err !== e.err) begin
                n_bad++;
                $display("FAIL o_par_err: got %b expected %b", bus.o_par_err, e.err);
            end
            if (r) begin
                void'(q.pop_front());
                out_cnt++;
                if ((|e.err) && exp_err_cnt != (1 << ECW) - 1) exp_err_cnt++;
            end
        end
        if (acc) q.push_back(ref_group(wa, wb, wc, wd));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b0;
        @(posedge clk);
        #1;
        n_vec++;
        if (bus.o_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset o_valid: got %b expected 0", bus.o_valid);
        end
        n_vec++;
        if (bus.o_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL reset o_ready: got %b expected 0", bus.o_ready);
        end
        n_vec++;
        if (bus.o_err_cnt !== '0 || bus.o_par_err !== 4'b0000 || bus.o_am_start !== 1'b0) begin
            n_bad++;
            $display("FAIL reset status: err_cnt %0d par_err %b am_start %b expected 0 0000 0",
                     bus.o_err_cnt, bus.o_par_err, bus.o_am_start);
        end
        n_vec++;
        if (bus.rx_f0 !== '0 || bus.rx_f1 !== '0) begin
            n_bad++;
            $display("FAIL reset flows: f0 sym0 %h f1 sym0 %h expected 0", flow_sym(bus.rx_f0, 0), flow_sym(bus.rx_f1, 0));
        end
        rst = 1'b0;
        q.delete();
        out_cnt     = 0;
        exp_err_cnt = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
    endtask

    task automatic test_mapping();
        pattern_words();
        cycle(1'b1, 1'b1);
        n_vec++;
        if (bus.o_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL map latency: o_valid got %b expected 1", bus.o_valid);
        end
        n_vec++;
        if (flow_sym(bus.rx_f0, 0) !== 10'h000 || flow_sym(bus.rx_f0, 1) !== 10'h100) begin
            n_bad++;
            $display("FAIL map f0 head: got %h %h expected 000 100", flow_sym(bus.rx_f0, 0), flow_sym(bus.rx_f0, 1));
        end
        n_vec++;
        if (flow_sym(bus.rx_f1, 600) !== 10'h22c || flow_sym(bus.rx_f1, 1027) !== 10'h301) begin
            n_bad++;
            $display("FAIL map f1 syms: got %h %h expected 22c 301", flow_sym(bus.rx_f1, 600), flow_sym(bus.rx_f1, 1027));
        end
        cycle(1'b0, 1'b1);
    endtask

    task automatic test_backpressure();
        rand_words(); cycle(1'b1, 1'b0);
        rand_words(); cycle(1'b1, 1'b0);
        rand_words();
        repeat (3) cycle(1'b1, 1'b0);
        n_vec++;
        if (bus.o_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL backpressure o_ready: got %b expected 0", bus.o_ready);
        end
        cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b1);
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b1);
    endtask

    task automatic test_simultaneous();
        rand_words();
        cycle(1'b1, 1'b1);
        for (int i = 0; i < 10; i++) begin
            rand_words();
            cycle(1'b1, 1'b1);
        end
        cycle(1'b0, 1'b1);
    endtask

    task automatic test_am_wrap();
        logic [8:0] am_seen;
        int         n;
        do_reset();
        am_seen = '0;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.o_valid === 1'b1 && n < 9) begin
                am_seen[n] = bus.o_am_start;
                n++;
            end
            rand_words();
            cycle(i < 9, 1'b1);
        end
        n_vec++;
        if (n != 9 || am_seen !== 9'b1_0001_0001) begin
            n_bad++;
            $display("FAIL am_wrap: got %0d outputs pattern %b expected 9 outputs 100010001", n, am_seen);
        end
    endtask

    task automatic test_parity();
        logic [3:0] pe [4];
        int         n;
        logic [3:0] exp_pe;
        int         exp_cnt;
`ifdef RS_DEMAP_PARITY_CHECK_EN
        exp_pe  = 4'b0100;
        exp_cnt = 1;
`else
        exp_pe  = 4'b0000;
        exp_cnt = 0;
`endif
        do_reset();
        n = 0;
        for (int g = 0; g < 5; g++) begin
            if (bus.o_valid === 1'b1 && n < 4) begin
                pe[n] = bus.o_par_err;
                n++;
            end
            pattern_words();
            if (g == 1) wc[0] = ~wc[0];
            cycle(g < 4, 1'b1);
        end
        n_vec++;
        if (n != 4 || pe[0] !== 4'b0000 || pe[1] !== exp_pe || pe[2] !== 4'b0000 || pe[3] !== 4'b0000) begin
            n_bad++;
            $display("FAIL parity flags: got %0d outputs %b %b %b %b expected 0000 %b 0000 0000",
                     n, pe[0], pe[1], pe[2], pe[3], exp_pe);
        end
        n_vec++;
        if (bus.o_err_cnt !== ECW'(exp_cnt)) begin
            n_bad++;
            $display("FAIL parity err_cnt: got %0d expected %0d", bus.o_err_cnt, exp_cnt);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            rand_words();
            if ($urandom_range(0, 3) == 0) begin
                pattern_words();
                wa[$urandom_range(0, PW - 1)] ^= 1'b1;
            end
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
        end
    endtask

    task automatic test_reset_full();
        rand_words(); cycle(1'b1, 1'b0);
        rand_words(); cycle(1'b1, 1'b0);
        do_reset();
        repeat (4) cycle(1'b0, 1'b1);
        rand_words();
        cycle(1'b1, 1'b1);
        cycle(1'b0, 1'b1);
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        n_vec = 0;
        n_bad = 0;
        out_cnt = 0;
        exp_err_cnt = 0;
        wa = '0; wb = '0; wc = '0; wd = '0;
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b0;
        bus.word_A = '0;
        bus.word_B = '0;
        bus.word_C = '0;
        bus.word_D = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_mapping();
        test_backpressure();
        test_simultaneous();
        test_am_wrap();
        test_parity();
        test_random();
        test_reset_full();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
